// File: rtl/mod_acc_framer_pkg.sv
// Shared definitions for the mod_acc framing front end.
//   CNT_W     : element counter width for a given group length (minimum 1)
//   side_w    : physical width of the side-data path (1 when side data is unused)
//   TWO_MOD_M : range-check limit for the default 33-bit modulus
package mod_acc_framer_pkg;

  localparam int unsigned OP_W_DEF = 33;
  localparam logic [OP_W_DEF-1:0] MOD_M_DEF = 33'h1_FFF0_0001;
  localparam logic [OP_W_DEF:0] TWO_MOD_M = {MOD_M_DEF, 1'b0};

  function automatic int unsigned CNT_W(input int unsigned acc_nb);
    return (acc_nb > 1) ? $clog2(acc_nb) : 1;
  endfunction

  // Zero-width side data is carried on a single dummy bit.
  function automatic int unsigned side_w(input int unsigned w);
    return (w > 0) ? w : 1;
  endfunction

endpackage

// File: rtl/mod_acc_framer_if.sv
// Stream interface for mod_acc_framer.
//   in_op/in_avail/in_flush/in_side : unframed operand stream into the framer
//   out_op/out_sol/out_eol/out_avail/out_side/err_range : framed stream to mod_acc
//   master : stream producer / result consumer
//   slave  : the framer
interface mod_acc_framer_if
  import mod_acc_framer_pkg::*;
#(
  parameter int unsigned OP_W   = 33,
  parameter int unsigned SIDE_W = 0
);

  localparam int unsigned SW = side_w(SIDE_W);

  logic [OP_W:0]   in_op;
  logic            in_avail;
  logic            in_flush;
  logic [SW-1:0]   in_side;

  logic [OP_W-1:0] out_op;
  logic            out_sol;
  logic            out_eol;
  logic            out_avail;
  logic [SW-1:0]   out_side;
  logic            err_range;

  modport master (
    output in_op, in_avail, in_flush, in_side,
    input  out_op, out_sol, out_eol, out_avail, out_side, err_range
  );

  modport slave (
    input  in_op, in_avail, in_flush, in_side,
    output out_op, out_sol, out_eol, out_avail, out_side, err_range
  );

endinterface

// File: rtl/common_lib_delay_side.sv
// One-cycle register stage for side data with selectable reset behaviour.
//   clk, s_rst_n : clock, synchronous active-low reset
//   in_side      : side data in
//   out_side     : side data delayed by one cycle
//   RST_SIDE     : [0]=1 reset to zero, else [1]=1 reset to all ones, else no reset
module common_lib_delay_side #(
  parameter int unsigned W        = 1,
  parameter logic [1:0]  RST_SIDE = 2'b00
) (
  input  logic         clk,
  input  logic         s_rst_n,
  input  logic [W-1:0] in_side,
  output logic [W-1:0] out_side
);

  generate
    if (RST_SIDE[0]) begin : g_rst_zero
      always_ff @(posedge clk) begin
        if (!s_rst_n) out_side <= '0;
        else          out_side <= in_side;
      end
    end else if (RST_SIDE[1]) begin : g_rst_ones
      always_ff @(posedge clk) begin
        if (!s_rst_n) out_side <= '1;
        else          out_side <= in_side;
      end
    end else begin : g_no_rst
      logic rst_unused;
      assign rst_unused = s_rst_n;
      always_ff @(posedge clk) begin
        out_side <= in_side;
      end
    end
  endgenerate

endmodule

// File: rtl/mod_acc_framer_cnt.sv
// Element counter that frames the valid stream into groups of ACC_NB.
//   clk, s_rst_n : clock, synchronous active-low reset
//   avail        : current element is valid (counter advances only then)
//   flush        : close the group on the current element (pre-qualified by avail)
//   sol, eol     : first / last element of group for the current element
module mod_acc_framer_cnt
  import mod_acc_framer_pkg::*;
#(
  parameter int unsigned ACC_NB = 16
) (
  input  logic clk,
  input  logic s_rst_n,
  input  logic avail,
  input  logic flush,
  output logic sol,
  output logic eol
);

  localparam int unsigned CW = CNT_W(ACC_NB);
  localparam logic [CW-1:0] LAST = CW'(ACC_NB - 1);

  logic [CW-1:0] cnt;

  assign sol = (cnt == '0);
  assign eol = (cnt == LAST) || flush;

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      cnt <= '0;
    end else if (avail) begin
      cnt <= eol ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mod_acc_framer.sv
// Framing and pre-reduction stage ahead of mod_acc. Reduces operands from
// [0, 2*MOD_M) into [0, MOD_M) and marks accumulation groups of ACC_NB
// elements with sol/eol. Fixed two-cycle latency, no back-pressure.
//   clk, s_rst_n : clock, synchronous active-low reset
//   bus (slave)  : in_op/in_avail/in_flush/in_side in,
//                  out_op/out_sol/out_eol/out_avail/out_side/err_range out
// Build option: MOD_ACC_FRAMER_FLUSH_EN honours in_flush (early group close);
// without it every group is exactly ACC_NB elements.
module mod_acc_framer
  import mod_acc_framer_pkg::*;
#(
  parameter int unsigned     OP_W     = 33,
  parameter logic [OP_W-1:0] MOD_M    = 33'h1_FFF0_0001,
  parameter int unsigned     ACC_NB   = 16,
  parameter int unsigned     SIDE_W   = 0,
  parameter logic [1:0]      RST_SIDE = 2'b00
) (
  input  logic            clk,
  input  logic            s_rst_n,
  mod_acc_framer_if.slave bus
);

  localparam int unsigned SW = side_w(SIDE_W);
  localparam logic [OP_W:0] MOD_M_X   = {1'b0, MOD_M};
  localparam logic [OP_W:0] RANGE_LIM = {MOD_M, 1'b0};

  // s0 registers
  logic [OP_W:0]   s0_op;
  logic            s0_avail;
  logic            s0_flush_q;
  logic [SW-1:0]   s0_side;

  // s0 combinational
  logic [OP_W:0]   d;
  logic            d_msb_unused;
  logic [OP_W-1:0] red;
  logic            range_err;
  logic            cnt_sol;
  logic            cnt_eol;

  // s1 registers
  logic [OP_W-1:0] s1_op;
  logic            s1_sol;
  logic            s1_eol;
  logic            s1_avail;
  logic            s1_err;

  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      s0_op    <= '0;
      s0_avail <= 1'b0;
    end else begin
      s0_op    <= bus.in_op;
      s0_avail <= bus.in_avail;
    end
  end

`ifdef MOD_ACC_FRAMER_FLUSH_EN
  logic s0_flush;

  always_ff @(posedge clk) begin
    if (!s_rst_n) s0_flush <= 1'b0;
    else          s0_flush <= bus.in_flush;
  end

  // A flush on an idle cycle must not touch the counter.
  assign s0_flush_q = s0_flush & s0_avail;
`else
  logic flush_unused;
  assign flush_unused = bus.in_flush;
  assign s0_flush_q   = 1'b0;
`endif

  common_lib_delay_side #(
    .W        (SW),
    .RST_SIDE (RST_SIDE)
  ) u_side_s0 (
    .clk      (clk),
    .s_rst_n  (s_rst_n),
    .in_side  (bus.in_side),
    .out_side (s0_side)
  );

  assign d_msb_unused = d[OP_W];

  always_comb begin
    d         = s0_op - MOD_M_X;
    range_err = (s0_op >= RANGE_LIM);
    if (range_err)              red = '0;
    else if (s0_op < MOD_M_X)   red = s0_op[OP_W-1:0];
    else                        red = d[OP_W-1:0];
  end

  mod_acc_framer_cnt #(
    .ACC_NB (ACC_NB)
  ) u_cnt (
    .clk     (clk),
    .s_rst_n (s_rst_n),
    .avail   (s0_avail),
    .flush   (s0_flush_q),
    .sol     (cnt_sol),
    .eol     (cnt_eol)
  );

  // Control flags are gated by avail so idle cycles carry no framing.
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      s1_op    <= '0;
      s1_sol   <= 1'b0;
      s1_eol   <= 1'b0;
      s1_avail <= 1'b0;
      s1_err   <= 1'b0;
    end else begin
      s1_op    <= red;
      s1_sol   <= s0_avail & cnt_sol;
      s1_eol   <= s0_avail & cnt_eol;
      s1_avail <= s0_avail;
      s1_err   <= s0_avail & range_err;
    end
  end

  common_lib_delay_side #(
    .W        (SW),
    .RST_SIDE (RST_SIDE)
  ) u_side_s1 (
    .clk      (clk),
    .s_rst_n  (s_rst_n),
    .in_side  (s0_side),
    .out_side (bus.out_side)
  );

  assign bus.out_op    = s1_op;
  assign bus.out_sol   = s1_sol;
  assign bus.out_eol   = s1_eol;
  assign bus.out_avail = s1_avail;
  assign bus.err_range = s1_err;

endmodule

// File: tb/tb_mod_acc_framer.sv
// Directed bench for mod_acc_framer: MOD_M=17, OP_W=5, side width 4.
// dut_a: ACC_NB=4, side resets to all ones. dut_b: ACC_NB=1, side resets to zero.
// Inputs are driven on the falling edge; outputs for a vector driven at
// falling edge k are sampled at falling edge k+2.
module tb_mod_acc_framer;

  logic clk;
  logic rst_n;
  int unsigned n_pass;
  int unsigned n_total;

  mod_acc_framer_if #(.OP_W(5), .SIDE_W(4)) bus_a ();
  mod_acc_framer_if #(.OP_W(5), .SIDE_W(4)) bus_b ();

  mod_acc_framer #(
    .OP_W(5), .MOD_M(5'd17), .ACC_NB(4), .SIDE_W(4), .RST_SIDE(2'b10)
  ) dut_a (
    .clk(clk), .s_rst_n(rst_n), .bus(bus_a)
  );

  mod_acc_framer #(
    .OP_W(5), .MOD_M(5'd17), .ACC_NB(1), .SIDE_W(4), .RST_SIDE(2'b01)
  ) dut_b (
    .clk(clk), .s_rst_n(rst_n), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Expected tuple {avail, sol, eol, err, op[4:0], side[3:0]}
  function automatic logic [12:0] ex(input int av, input int sol, input int eol,
                                     input int err, input int op, input int sd);
    return {av[0], sol[0], eol[0], err[0], op[4:0], sd[3:0]};
  endfunction

  function automatic logic [12:0] obs_a();
    return {bus_a.out_avail, bus_a.out_sol, bus_a.out_eol, bus_a.err_range,
            bus_a.out_op, bus_a.out_side};
  endfunction

  function automatic logic [12:0] obs_b();
    return {bus_b.out_avail, bus_b.out_sol, bus_b.out_eol, bus_b.err_range,
            bus_b.out_op, bus_b.out_side};
  endfunction

  task automatic drive_a(input int op, input int av, input int fl, input int sd);
    bus_a.in_op    = op[5:0];
    bus_a.in_avail = av[0];
    bus_a.in_flush = fl[0];
    bus_a.in_side  = sd[3:0];
  endtask

  task automatic drive_b(input int op, input int av, input int fl, input int sd);
    bus_b.in_op    = op[5:0];
    bus_b.in_avail = av[0];
    bus_b.in_flush = fl[0];
    bus_b.in_side  = sd[3:0];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if (obs_a() !== ex(0, 0, 0, 0, 0, 15))
      $display("FAIL reset_a: got %h want %h", obs_a(), ex(0, 0, 0, 0, 0, 15));
    else n_pass++;
    n_total++;
    if (obs_b() !== ex(0, 0, 0, 0, 0, 0))
      $display("FAIL reset_b: got %h want %h", obs_b(), ex(0, 0, 0, 0, 0, 0));
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_reduce();
    int v [4][4] = '{'{3, 1, 0, 1}, '{20, 1, 0, 2}, '{16, 1, 0, 3}, '{33, 1, 0, 4}};
    int e [4][6] = '{'{1, 1, 0, 0, 3, 1}, '{1, 0, 0, 0, 3, 2},
                     '{1, 0, 0, 0, 16, 3}, '{1, 0, 1, 0, 16, 4}};
    logic [12:0] want;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        want = ex(e[i-2][0], e[i-2][1], e[i-2][2], e[i-2][3], e[i-2][4], e[i-2][5]);
        n_total++;
        if (obs_a() !== want) $display("FAIL reduce[%0d]: got %h want %h", i - 2, obs_a(), want);
        else n_pass++;
      end
      if (i < 4) drive_a(v[i][0], v[i][1], v[i][2], v[i][3]);
      else       drive_a(0, 0, 0, 0);
    end
  endtask

  task automatic test_range();
    int v [5][4] = '{'{34, 1, 0, 8}, '{5, 1, 0, 9}, '{63, 1, 0, 10}, '{17, 1, 0, 11},
                     '{0, 0, 0, 0}};
    int e [5][6] = '{'{1, 1, 0, 1, 0, 8}, '{1, 0, 0, 0, 5, 9}, '{1, 0, 0, 1, 0, 10},
                     '{1, 0, 1, 0, 0, 11}, '{0, 0, 0, 0, 0, 0}};
    logic [12:0] want;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        want = ex(e[i-2][0], e[i-2][1], e[i-2][2], e[i-2][3], e[i-2][4], e[i-2][5]);
        n_total++;
        if (obs_a() !== want) $display("FAIL range[%0d]: got %h want %h", i - 2, obs_a(), want);
        else n_pass++;
      end
      if (i < 5) drive_a(v[i][0], v[i][1], v[i][2], v[i][3]);
      else       drive_a(0, 0, 0, 0);
    end
  endtask

  task automatic test_gaps();
    int v [6][4] = '{'{1, 1, 0, 0}, '{9, 0, 0, 1}, '{2, 1, 0, 2},
                     '{9, 0, 0, 3}, '{3, 1, 0, 4}, '{4, 1, 0, 5}};
    int e [6][6] = '{'{1, 1, 0, 0, 1, 0}, '{0, 0, 0, 0, 9, 1}, '{1, 0, 0, 0, 2, 2},
                     '{0, 0, 0, 0, 9, 3}, '{1, 0, 0, 0, 3, 4}, '{1, 0, 1, 0, 4, 5}};
    logic [12:0] want;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        want = ex(e[i-2][0], e[i-2][1], e[i-2][2], e[i-2][3], e[i-2][4], e[i-2][5]);
        n_total++;
        if (obs_a() !== want) $display("FAIL gaps[%0d]: got %h want %h", i - 2, obs_a(), want);
        else n_pass++;
      end
      if (i < 6) drive_a(v[i][0], v[i][1], v[i][2], v[i][3]);
      else       drive_a(0, 0, 0, 0);
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] want;
    int e [4][6] = '{'{1, 1, 0, 0, 4, 4}, '{1, 0, 0, 0, 5, 5},
                     '{1, 0, 0, 0, 6, 6}, '{1, 0, 1, 0, 7, 7}};
    @(negedge clk); drive_a(1, 1, 0, 1);
    @(negedge clk); drive_a(2, 1, 0, 2);
    @(negedge clk);
    n_total++;
    if (obs_a() !== ex(1, 1, 0, 0, 1, 1))
      $display("FAIL rstmid_first: got %h want %h", obs_a(), ex(1, 1, 0, 0, 1, 1));
    else n_pass++;
    rst_n = 1'b0;
    drive_a(3, 1, 0, 3);
    @(negedge clk);
    n_total++;
    if (obs_a() !== ex(0, 0, 0, 0, 0, 15))
      $display("FAIL rstmid_held: got %h want %h", obs_a(), ex(0, 0, 0, 0, 0, 15));
    else n_pass++;
    rst_n = 1'b1;
    drive_a(0, 0, 0, 0);
    @(negedge clk);
    n_total++;
    if (obs_a() !== ex(0, 0, 0, 0, 0, 15))
      $display("FAIL rstmid_drop: got %h want %h", obs_a(), ex(0, 0, 0, 0, 0, 15));
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i >= 2) begin
        want = ex(e[i-2][0], e[i-2][1], e[i-2][2], e[i-2][3], e[i-2][4], e[i-2][5]);
        n_total++;
        if (obs_a() !== want) $display("FAIL rstmid_next[%0d]: got %h want %h", i - 2, obs_a(), want);
        else n_pass++;
      end
      if (i < 4) drive_a(4 + i, 1, 0, 4 + i);
      else       drive_a(0, 0, 0, 0);
    end
  endtask

  task automatic test_flush();
    int v [7][4] = '{'{5, 1, 0, 0}, '{6, 1, 1, 1}, '{7, 1, 0, 2}, '{0, 0, 1, 3},
                     '{8, 1, 0, 4}, '{9, 1, 0, 5}, '{10, 1, 0, 6}};
`ifdef MOD_ACC_FRAMER_FLUSH_EN
    int e [7][6] = '{'{1, 1, 0, 0, 5, 0}, '{1, 0, 1, 0, 6, 1}, '{1, 1, 0, 0, 7, 2},
                     '{0, 0, 0, 0, 0, 3}, '{1, 0, 0, 0, 8, 4}, '{1, 0, 0, 0, 9, 5},
                     '{1, 0, 1, 0, 10, 6}};
`else
    int e [7][6] = '{'{1, 1, 0, 0, 5, 0}, '{1, 0, 0, 0, 6, 1}, '{1, 0, 0, 0, 7, 2},
                     '{0, 0, 0, 0, 0, 3}, '{1, 0, 1, 0, 8, 4}, '{1, 1, 0, 0, 9, 5},
                     '{1, 0, 0, 0, 10, 6}};
`endif
    logic [12:0] want;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        want = ex(e[i-2][0], e[i-2][1], e[i-2][2], e[i-2][3], e[i-2][4], e[i-2][5]);
        n_total++;
        if (obs_a() !== want) $display("FAIL flush[%0d]: got %h want %h", i - 2, obs_a(), want);
        else n_pass++;
      end
      if (i < 7) drive_a(v[i][0], v[i][1], v[i][2], v[i][3]);
      else       drive_a(0, 0, 0, 0);
    end
  endtask

  task automatic test_acc_nb1();
    int v [4][4] = '{'{3, 1, 0, 1}, '{0, 0, 0, 0}, '{20, 1, 0, 2}, '{34, 1, 0, 3}};
    int e [4][6] = '{'{1, 1, 1, 0, 3, 1}, '{0, 0, 0, 0, 0, 0},
                     '{1, 1, 1, 0, 3, 2}, '{1, 1, 1, 1, 0, 3}};
    logic [12:0] want;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        want = ex(e[i-2][0], e[i-2][1], e[i-2][2], e[i-2][3], e[i-2][4], e[i-2][5]);
        n_total++;
        if (obs_b() !== want) $display("FAIL nb1[%0d]: got %h want %h", i - 2, obs_b(), want);
        else n_pass++;
      end
      if (i < 4) drive_b(v[i][0], v[i][1], v[i][2], v[i][3]);
      else       drive_b(0, 0, 0, 0);
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    drive_a(0, 0, 0, 0);
    drive_b(0, 0, 0, 0);
    test_reset();
    test_reduce();
    test_range();
    test_gaps();
    test_reset_mid();
    test_flush();
    test_acc_nb1();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
